// File: rtl/boid_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : boid_frame_writer
// Purpose  : Per-frame erase-then-draw of boid pixels into the 1-bit display RAM.
// Revision : 1.0 - initial release
// ============================================================================
module boid_frame_writer #(
  parameter int MAX_BOIDS      = 8,
  parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int VIDEO_WIDTH    = 640,
  parameter int VIDEO_HEIGHT   = 480,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic [BITS_FOR_BOIDS:0]   num_active,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  input  logic [9:0]                boid_x,
  input  logic [8:0]                boid_y,
  output logic                      fb_we,
  output logic [ADDR_WIDTH-1:0]     fb_addr,
  output logic                      fb_wdata,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    FETCH = 2'd2
  } state_t;

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_IDX = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
  localparam logic [BITS_FOR_BOIDS:0]   CNT_MAX  = (BITS_FOR_BOIDS + 1)'(MAX_BOIDS);
  localparam logic [9:0]                X_LIMIT  = 10'(VIDEO_WIDTH);
  localparam logic [8:0]                Y_LIMIT  = 9'(VIDEO_HEIGHT);

  state_t                      state, state_next;
  logic [BITS_FOR_BOIDS-1:0]   idx, idx_next;
  logic [BITS_FOR_BOIDS:0]     num_lat;
  logic [MAX_BOIDS-1:0]        prev_valid;
  logic [ADDR_WIDTH-1:0]       prev_addr [MAX_BOIDS];

  logic                        accept;
  logic                        in_range;
  logic [ADDR_WIDTH-1:0]       pix_addr;
  logic                        wr_en;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic                        wr_data;
  logic                        tbl_upd;
  logic                        tbl_valid;
  logic                        done_next;

  // frame_done marks the final write slot, which still belongs to the burst.
  assign busy   = (state != IDLE) || frame_done;
  assign accept = frame_start && (state == IDLE) && !frame_done;

  // y*640 + x as shifts; out-of-range coordinates are filtered, never wrapped.
  assign pix_addr = (ADDR_WIDTH'(boid_y) << 9) + (ADDR_WIDTH'(boid_y) << 7)
                  + ADDR_WIDTH'(boid_x);
  assign in_range = ({1'b0, idx} < num_lat) && (boid_x < X_LIMIT) && (boid_y < Y_LIMIT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    wr_en      = 1'b0;
    wr_addr    = fb_addr;
    wr_data    = fb_wdata;
    tbl_upd    = 1'b0;
    tbl_valid  = 1'b0;
    done_next  = 1'b0;
    boid_sel   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ERASE;
          idx_next   = '0;
        end
      end
      ERASE: begin
        if (prev_valid[idx]) begin
          wr_en   = 1'b1;
          wr_addr = prev_addr[idx];
          wr_data = 1'b0;
        end
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          state_next = FETCH;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      FETCH: begin
        boid_sel  = idx;
        tbl_upd   = 1'b1;
        tbl_valid = in_range;
        if (in_range) begin
          wr_en   = 1'b1;
          wr_addr = pix_addr;
          wr_data = 1'b1;
        end
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx           <= '0;
      num_lat       <= '0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_wdata      <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      prev_valid    <= '0;
      for (int i = 0; i < MAX_BOIDS; i++) begin
        prev_addr[i] <= '0;
      end
    end else begin
      idx           <= idx_next;
      fb_we         <= wr_en;
      fb_addr       <= wr_addr;
      fb_wdata      <= wr_data;
      frame_done    <= done_next;
      frame_overrun <= frame_start && busy;
      if (accept) begin
        num_lat <= (num_active > CNT_MAX) ? CNT_MAX : num_active;
      end
      if (tbl_upd) begin
        prev_valid[idx] <= tbl_valid;
        if (tbl_valid) begin
          prev_addr[idx] <= pix_addr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boid_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_boid_frame_writer
// Purpose  : Scoreboard bench for boid_frame_writer with directed boid frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boid_frame_writer;

  localparam int N  = 8;
  localparam int AW = 19;

  logic          clock;
  logic          reset_n;
  logic          frame_start;
  logic [3:0]    num_active;
  logic [2:0]    boid_sel;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic          fb_wdata;
  logic          busy;
  logic          frame_done;
  logic          frame_overrun;

  boid_frame_writer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .num_active    (num_active),
    .boid_sel      (boid_sel),
    .boid_x        (boid_x),
    .boid_y        (boid_y),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_wdata      (fb_wdata),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  wr_t           sb [$];
  wr_t           mon_e;
  logic [9:0]    bx [N];
  logic [8:0]    by [N];
  logic          mvalid [N];
  logic [AW-1:0] maddr [N];

  int cyc        = 0;
  int checks     = 0;
  int errors     = 0;
  int last_start = -1000;
  int abort_cyc  = 1 << 30;
  int ov_a       = -1;
  int ov_b       = -1;
  logic mon_on   = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural stand-in for the BPU output mux.
  always_comb begin
    boid_x = bx[boid_sel];
    boid_y = by[boid_sel];
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) next_cycle();
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_fb_we"},         int'(fb_we),         0);
    check_eq({tag, "_fb_addr"},       int'(fb_addr),       0);
    check_eq({tag, "_fb_wdata"},      int'(fb_wdata),      0);
    check_eq({tag, "_busy"},          int'(busy),          0);
    check_eq({tag, "_frame_done"},    int'(frame_done),    0);
    check_eq({tag, "_frame_overrun"}, int'(frame_overrun), 0);
    check_eq({tag, "_boid_sel"},      int'(boid_sel),      0);
  endtask

  // Drives a one-cycle frame_start now and queues the writes the frame must produce.
  task automatic start_frame(input int n);
    int  n_eff;
    int  a;
    wr_t w;
    n_eff       = (n > N) ? N : n;
    frame_start = 1'b1;
    num_active  = 4'(n);
    last_start  = cyc;
    abort_cyc   = 1 << 30;
    for (int k = 0; k < N; k++) begin
      if (mvalid[k]) begin
        w.cyc = last_start + 2 + k; w.addr = maddr[k]; w.data = 1'b0;
        sb.push_back(w);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (k < n_eff && int'(bx[k]) < 640 && int'(by[k]) < 480) begin
        a = int'(by[k]) * 640 + int'(bx[k]);
        w.cyc = last_start + N + 2 + k; w.addr = AW'(a); w.data = 1'b1;
        sb.push_back(w);
        mvalid[k] = 1'b1;
        maddr[k]  = AW'(a);
      end else begin
        mvalid[k] = 1'b0;
      end
    end
    next_cycle();
    frame_start = 1'b0;
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      logic       exp_busy, exp_done, exp_ov;
      logic [2:0] exp_sel;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: cycle %0d got no write, required addr=%0d data=%0d at cycle %0d",
                 cyc, sb[0].addr, sb[0].data, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (fb_we) begin
        checks++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_write: cycle %0d got addr=%0d data=%0d, required no write",
                   cyc, fb_addr, fb_wdata);
        end else begin
          mon_e = sb.pop_front();
          if (fb_addr !== mon_e.addr || fb_wdata !== mon_e.data) begin
            errors++;
            $display("FAIL write_value: cycle %0d got addr=%0d data=%0d, required addr=%0d data=%0d",
                     cyc, fb_addr, fb_wdata, mon_e.addr, mon_e.data);
          end
        end
      end
      exp_busy = (cyc >= last_start + 1) && (cyc <= last_start + 2*N + 1) && (cyc < abort_cyc);
      exp_done = (cyc == last_start + 2*N + 1) && (cyc < abort_cyc);
      exp_ov   = (cyc == ov_a) || (cyc == ov_b);
      exp_sel  = ((cyc >= last_start + N + 1) && (cyc <= last_start + 2*N) && (cyc < abort_cyc))
                 ? 3'(cyc - (last_start + N + 1)) : 3'd0;
      checks++;
      if (busy !== exp_busy || frame_done !== exp_done || frame_overrun !== exp_ov ||
          boid_sel !== exp_sel) begin
        errors++;
        $display("FAIL status: cycle %0d got busy=%0b done=%0b ovr=%0b sel=%0d, required busy=%0b done=%0b ovr=%0b sel=%0d",
                 cyc, busy, frame_done, frame_overrun, boid_sel, exp_busy, exp_done, exp_ov, exp_sel);
      end
    end
  end

  initial begin
    int  c;
    wr_t keep [$];
    reset_n     = 1'b0;
    frame_start = 1'b0;
    num_active  = '0;
    for (int k = 0; k < N; k++) begin
      bx[k] = '0; by[k] = '0; mvalid[k] = 1'b0; maddr[k] = '0;
    end
    next_cycle();
    next_cycle();
    mon_on = 1'b1;
    @(negedge clock);
    check_outputs_zero("reset");
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Eight boids in a row on line 10: writes 6410..6417, nothing to erase.
    for (int k = 0; k < N; k++) begin
      bx[k] = 10'(10 + k); by[k] = 9'd10;
    end
    start_frame(8);
    wait_until(last_start + 18);

    // Boid 0 jumps to the origin.
    bx[0] = 10'd0; by[0] = 9'd0;
    start_frame(8);
    wait_until(last_start + 18);

    // Off-screen boids are skipped; bottom-right pixel lands at 307199.
    bx[3] = 10'd640; by[3] = 9'd5;
    bx[4] = 10'd5;   by[4] = 9'd480;
    bx[7] = 10'd639; by[7] = 9'd479;
    start_frame(8);
    wait_until(last_start + 18);
    start_frame(8);
    wait_until(last_start + 18);

    // Partial and empty populations, then an oversize count that must clamp.
    start_frame(2);
    wait_until(last_start + 18);
    start_frame(0);
    wait_until(last_start + 18);
    start_frame(15);
    wait_until(last_start + 18);

    // frame_start during a burst is ignored; the cycle after frame_done is accepted.
    start_frame(8);
    c = last_start;
    wait_until(c + 5);
    frame_start = 1'b1;
    ov_a = c + 6;
    next_cycle();
    frame_start = 1'b0;
    wait_until(c + 17);
    frame_start = 1'b1;
    ov_b = c + 18;
    next_cycle();
    start_frame(8);
    wait_until(last_start + 18);

    // Reset mid-burst: outputs clear, and the following frame has nothing to erase.
    start_frame(8);
    c = last_start;
    wait_until(c + 12);
    reset_n   = 1'b0;
    abort_cyc = c + 13;
    keep.delete();
    foreach (sb[i]) if (sb[i].cyc <= c + 12) keep.push_back(sb[i]);
    sb = keep;
    for (int k = 0; k < N; k++) mvalid[k] = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clock);
    check_outputs_zero("midreset");
    next_cycle();
    start_frame(8);
    wait_until(last_start + 18);

    repeat (4) next_cycle();
    check_eq("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
